qam_stream_mapper: RTL



---
 rtl/qam_stream_mapper.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/qam_stream_mapper.sv
// ---------------------------------------------------------------------------
// qam_stream_mapper
//
// Streaming Gray-coded QAM mapper. Packed input beats are appended to a bit
// accumulator, and the oldest bits are mapped into one registered signed I/Q
// symbol per output handshake. The mapper supports QPSK, 16-QAM and 64-QAM.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   mode     in   00 QPSK, 01 16-QAM, 10 64-QAM, 11 treated as 16-QAM
//   flush    in   drop accumulator residue that is shorter than one symbol
//   s_data   in   input beat, MSB consumed first
//   s_valid  in   input beat valid
//   s_ready  out  accumulator has room for a full beat
//   m_re     out  signed in-phase level
//   m_im     out  signed quadrature level
//   m_valid  out  symbol valid
//   m_ready  in   downstream accepts symbol
//   sym_cnt  out  16-bit handshake counter (only when QAM_SYMCNT_EN is defined)
//
// Optional feature macro: QAM_SYMCNT_EN
// ---------------------------------------------------------------------------
module qam_stream_mapper #(
  parameter  int IN_WIDTH  = 8,
  parameter  int OUT_WIDTH = 5,
  localparam int ACC_WIDTH = IN_WIDTH + 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic                        flush,
  input  logic [IN_WIDTH-1:0]         s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic signed [OUT_WIDTH-1:0] m_re,
  output logic signed [OUT_WIDTH-1:0] m_im,
  output logic                        m_valid,
`ifdef QAM_SYMCNT_EN
  output logic [15:0]                 sym_cnt,
`endif
  input  logic                        m_ready
);

  localparam int FILL_W = $clog2(ACC_WIDTH + 1);
  localparam logic [FILL_W-1:0] IN_W_F    = FILL_W'(IN_WIDTH);
  localparam logic [FILL_W-1:0] READY_MAX = FILL_W'(ACC_WIDTH - IN_WIDTH);

  // Accumulator is MSB-aligned: bit ACC_WIDTH-1 is the oldest bit. Bits
  // below the fill level are always kept at zero so new beats can be OR-ed in.
  logic [ACC_WIDTH-1:0]        acc_q, acc_d;
  logic [FILL_W-1:0]           fill_q, fill_d;
  logic signed [OUT_WIDTH-1:0] m_re_q, m_re_d;
  logic signed [OUT_WIDTH-1:0] m_im_q, m_im_d;
  logic                        m_valid_q, m_valid_d;

  logic [1:0]           k;
  logic [FILL_W-1:0]    bps;
  logic [5:0]           sym;
  logic [2:0]           g_i, g_q;
  logic                 pop, push, flush_eff;
  logic [FILL_W-1:0]    fill_pop;
  logic [ACC_WIDTH-1:0] acc_shift;

  // Gray index -> binary index -> odd-integer level for an axis of k bits.
  function automatic logic signed [OUT_WIDTH-1:0] map_axis(input logic [2:0] g,
                                                           input logic [1:0] k_bits);
    logic [2:0] b;
    int         lvl;
    case (k_bits)
      2'd1:    b = {2'b00, g[0]};
      2'd2:    b = {1'b0, g[1], g[1] ^ g[0]};
      default: b = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endcase
    lvl = 2 * int'(b) - ((1 << k_bits) - 1);
    return OUT_WIDTH'(lvl);
  endfunction

  always_comb begin
    sym = acc_q[ACC_WIDTH-1 -: 6];
    case (mode)
      2'b00: begin
        k   = 2'd1;
        g_i = {2'b00, sym[5]};
        g_q = {2'b00, sym[4]};
      end
      2'b10: begin
        k   = 2'd3;
        g_i = sym[5:3];
        g_q = sym[2:0];
      end
      default: begin
        k   = 2'd2;
        g_i = {1'b0, sym[5:4]};
        g_q = {1'b0, sym[3:2]};
      end
    endcase
    bps = FILL_W'({k, 1'b0});

    s_ready   = (fill_q <= READY_MAX);
    push      = s_valid && s_ready;
    pop       = (fill_q >= bps) && (!m_valid_q || m_ready);
    // Flush only bites on a sub-symbol residue, which also means no pop.
    flush_eff = flush && (fill_q < bps);

    fill_pop  = pop ? (fill_q - bps) : fill_q;
    acc_shift = pop ? (acc_q << bps) : acc_q;

    acc_d  = acc_shift;
    fill_d = fill_pop;
    if (flush_eff) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (push) begin
      // fill_pop <= ACC_WIDTH-IN_WIDTH here, so no incoming bit falls off.
      acc_d  = acc_shift | ({s_data, 6'b000000} >> fill_pop);
      fill_d = fill_pop + IN_W_F;
    end

    m_re_d    = m_re_q;
    m_im_d    = m_im_q;
    m_valid_d = m_valid_q;
    if (pop) begin
      m_re_d    = map_axis(g_i, k);
      m_im_d    = map_axis(g_q, k);
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      fill_q    <= '0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      m_valid_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_re    = m_re_q;
  assign m_im    = m_im_q;
  assign m_valid = m_valid_q;

`ifdef QAM_SYMCNT_EN
  logic [15:0] sym_cnt_q, sym_cnt_d;

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    if (m_valid_q && m_ready) begin
      sym_cnt_d = sym_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q <= '0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
    end
  end

  assign sym_cnt = sym_cnt_q;
`endif

endmodule
